// File: rtl/gpu_vga_timing.sv
// gpu_vga_timing: 640x480@60 raster timing generator with registered, blanked colour and sync outputs
// Ports: clock/reset (synchronous, active-high); row/col scan counters; pixelTick one-clock pixel
//        strobe; videoOn visible-area flag; vgaIn colour for current row/col; vga/hsync/vsync
//        registered DAC outputs (syncs active-low, one pixel behind row/col).
// Optional: define GPU_VGA_FRAME_COUNT_EN to add frameStart (pulse on the 0,0 wrap tick) and
//           frameCount (16-bit frame counter).
module gpu_vga_timing #(
    parameter int CLOCK_DIV = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [9:0]  row,
    output logic [9:0]  col,
    output logic        pixelTick,
    output logic        videoOn,
    input  logic [11:0] vgaIn,
    output logic [11:0] vga,
    output logic        hsync,
    output logic        vsync
`ifdef GPU_VGA_FRAME_COUNT_EN
    ,
    output logic        frameStart,
    output logic [15:0] frameCount
`endif
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = CLOCK_DIV > 1 ? $clog2(CLOCK_DIV) : 1;
    logic [DIV_W-1:0] div;
    logic lineEnd, frameEnd, hRaw, vRaw;
    assign pixelTick = div == DIV_W'(CLOCK_DIV - 1);
    assign lineEnd   = col == 10'(H_TOTAL - 1);
    assign frameEnd  = lineEnd && row == 10'(V_TOTAL - 1);
    assign videoOn   = col < 10'(H_VISIBLE) && row < 10'(V_VISIBLE);
    assign hRaw      = col >= 10'(H_VISIBLE + H_FRONT) && col < 10'(H_VISIBLE + H_FRONT + H_SYNC);
    assign vRaw      = row >= 10'(V_VISIBLE + V_FRONT) && row < 10'(V_VISIBLE + V_FRONT + V_SYNC);
    always_ff @(posedge clock) begin
        if (reset) begin
            div   <= '0;
            col   <= '0;
            row   <= '0;
            vga   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            div <= pixelTick ? '0 : div + 1'b1;
            if (pixelTick) begin
                col   <= lineEnd ? '0 : col + 1'b1;
                row   <= frameEnd ? '0 : lineEnd ? row + 1'b1 : row;
                vga   <= videoOn ? vgaIn : 12'h000;
                hsync <= ~hRaw;
                vsync <= ~vRaw;
            end
        end
    end
`ifdef GPU_VGA_FRAME_COUNT_EN
    assign frameStart = pixelTick && frameEnd;
    always_ff @(posedge clock) begin
        if (reset) frameCount <= '0;
        else if (frameStart) frameCount <= frameCount + 1'b1;
    end
`endif
endmodule

// File: tb/tb_gpu_vga_timing.sv
// tb_gpu_vga_timing: scoreboard bench against an arithmetic raster model on a shrunken timing
module tb_gpu_vga_timing;
    localparam int CD = 2;
    localparam int HV = 20, HF = 3, HS = 4, HB = 3;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;
    typedef struct packed {
        logic [11:0] v;
        logic        h;
        logic        s;
    } outT;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [11:0] vgaIn = 12'h000;
    logic [9:0] row, col;
    logic pixelTick, videoOn, hsync, vsync;
    logic [11:0] vga;
`ifdef GPU_VGA_FRAME_COUNT_EN
    logic frameStart;
    logic [15:0] frameCount;
`endif
    outT expQ[$];
    int errors = 0, checks = 0;
    int k = 0;
    int curRow = 0, curCol = 0;
    logic sTick, sReset;
    gpu_vga_timing #(
        .CLOCK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock(clock), .reset(reset), .row(row), .col(col), .pixelTick(pixelTick),
        .videoOn(videoOn), .vgaIn(vgaIn), .vga(vga), .hsync(hsync), .vsync(vsync)
`ifdef GPU_VGA_FRAME_COUNT_EN
        , .frameStart(frameStart), .frameCount(frameCount)
`endif
    );
    always #5 clock = ~clock;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask
    // One clock of stimulus: k = clocks elapsed since the last reset edge, from which the whole
    // raster position follows by division.
    task automatic cycle(input logic r, input logic [11:0] c);
        int p;
        bit tick, vis;
        @(negedge clock);
        k = reset ? 0 : k + 1;
        p = k / CD;
        curCol = p % HT;
        curRow = (p / HT) % VT;
        tick = (k % CD) == CD - 1;
        vis = curCol < HV && curRow < VV;
        check("col", int'(col), curCol);
        check("row", int'(row), curRow);
        check("pixelTick", int'(pixelTick), int'(tick));
        check("videoOn", int'(videoOn), int'(vis));
`ifdef GPU_VGA_FRAME_COUNT_EN
        check("frameStart", int'(frameStart), int'(tick && curCol == HT - 1 && curRow == VT - 1));
        check("frameCount", int'(frameCount), (p / (HT * VT)) % 65536);
`endif
        reset = r;
        vgaIn = c;
        if (tick && !r)
            expQ.push_back({vis ? c : 12'h000,
                            !(curCol >= HV + HF && curCol < HV + HF + HS),
                            !(curRow >= VV + VF && curRow < VV + VF + VS)});
    endtask
    always @(posedge clock) begin
        outT e;
        sTick = pixelTick;
        sReset = reset;
        #1;
        if (sReset) begin
            check("vga_rst", int'(vga), 0);
            check("hsync_rst", int'(hsync), 1);
            check("vsync_rst", int'(vsync), 1);
            expQ.delete();
        end else if (sTick) begin
            if (expQ.size() == 0) begin
                check("unexpected_tick", 1, 0);
            end else begin
                e = expQ.pop_front();
                check("vga", int'(vga), int'(e.v));
                check("hsync", int'(hsync), int'(e.h));
                check("vsync", int'(vsync), int'(e.s));
            end
        end
    end
    initial begin
        int n;
        repeat (3) cycle(1'b1, 12'hFFF);
        repeat (FRAME + 300) cycle(1'b0, 12'($urandom));
        repeat (FRAME) cycle(1'b0, 12'hABC);
        n = 0;
        while (!(curRow == 5 && curCol == 25) && n < FRAME) begin
            cycle(1'b0, 12'($urandom));
            n++;
        end
        check("midframe_reached", n < FRAME ? 1 : 0, 1);
        cycle(1'b1, 12'($urandom));
        repeat (3 * FRAME + 4) cycle(1'b0, 12'($urandom));
        @(negedge clock);
        check("queue_drained", expQ.size() <= 1 ? 1 : 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
